// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt aggregator with per-source level/edge, mask, SW set, W1C and priority ID
// Ports:
//    clk        system clock
//    reset_n    asynchronous active-low reset
//    irq_in     source interrupt lines, active-high
//    address    register word address (0 STATUS, 1 MASK, 2 EDGE_SEL, 3 RAW, 4 ACTIVE_ID, 5 SW_SET)
//    chipselect slave select
//    write_n    active-low write strobe
//    writedata  write data
//    readdata   registered read data, valid one cycle after address
//    irq        registered combined interrupt to the CPU
module irq_aggregator #(
   parameter int N_IRQ       = 8,
   parameter int SYNC_STAGES = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [15:0]      writedata,
   output logic [15:0]      readdata,
   output logic             irq
);
   logic [N_IRQ-1:0] raw, prev, mask, edge_sel, edge_pending, pending, active, w, set, clr;
   logic             wr;
   logic [3:0]       id;
   logic [15:0]      rd_next;
   logic             unused;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign raw = irq_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
         always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) sync_q <= '0;
            else begin
               sync_q[0] <= irq_in;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         assign raw = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // writedata bits above N_IRQ are intentionally ignored
   assign unused  = ^writedata;
   assign wr      = chipselect && !write_n;
   assign w       = writedata[N_IRQ-1:0];
   assign set     = (raw & ~prev) | ((wr && address == 3'd5) ? w : '0);
   assign clr     = (wr && address == 3'd0) ? w : '0;
   assign pending = (edge_sel & edge_pending) | (~edge_sel & raw);
   assign active  = pending & mask;

   // scan from the top so the lowest active index wins
   always_comb begin
      id = '0;
      for (int i = N_IRQ-1; i >= 0; i--) if (active[i]) id = 4'(i);
   end

   always_comb begin
      rd_next = '0;
      case (address)
         3'd0:    rd_next = 16'(pending);
         3'd1:    rd_next = 16'(mask);
         3'd2:    rd_next = 16'(edge_sel);
         3'd3:    rd_next = 16'(raw);
         3'd4:    rd_next = {|active, 11'b0, id};
         default: rd_next = '0;
      endcase
   end

   // masking with edge_sel keeps level sources' latch at 0 and discards it on edge->level switch;
   // set is OR'd after the clear so a simultaneous set wins
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         prev         <= '0;
         edge_pending <= '0;
         mask         <= '0;
         edge_sel     <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         prev         <= raw;
         edge_pending <= edge_sel & (set | (edge_pending & ~clr));
         if (wr && address == 3'd1) mask <= w;
         if (wr && address == 3'd2) edge_sel <= w;
         readdata     <= rd_next;
         irq          <= |active;
      end
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: table-driven and scoreboard checks of irq_aggregator at SYNC_STAGES 0 and 2
module tb_irq_aggregator;
   typedef struct {
      logic [2:0]  addr;
      logic        wr;
      logic [15:0] wd;
      logic [7:0]  irqin;
      logic [15:0] rd;
      logic        irq;
   } vec_t;
   typedef struct {
      logic [15:0] rd;
      logic        irq;
   } exp_t;

   logic        clk = 0, reset_n = 0;
   logic [7:0]  irqin0 = 0, irqin2 = 0;
   logic [2:0]  addr0 = 0, addr2 = 0;
   logic        cs0 = 0, cs2 = 0, wn0 = 1, wn2 = 1;
   logic [15:0] wd0 = 0, wd2 = 0, rd0, rd2;
   logic        irq0, irq2;
   int          n_cmp = 0, n_bad = 0;
   vec_t        tbl[$];
   exp_t        sb[$];
   exp_t        e;

   always #5 clk = ~clk;

   irq_aggregator #(.N_IRQ(8), .SYNC_STAGES(0)) u0 (
      .clk(clk), .reset_n(reset_n), .irq_in(irqin0), .address(addr0), .chipselect(cs0),
      .write_n(wn0), .writedata(wd0), .readdata(rd0), .irq(irq0));

   irq_aggregator #(.N_IRQ(8), .SYNC_STAGES(2)) u2 (
      .clk(clk), .reset_n(reset_n), .irq_in(irqin2), .address(addr2), .chipselect(cs2),
      .write_n(wn2), .writedata(wd2), .readdata(rd2), .irq(irq2));

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] a, input logic w, input logic [15:0] d,
                               input logic [7:0] s, input logic [15:0] r, input logic q);
      vec_t v;
      v.addr = a; v.wr = w; v.wd = d; v.irqin = s; v.rd = r; v.irq = q;
      return v;
   endfunction

   initial begin
      // level source 0 tracks the line
      tbl.push_back(mk(3'd1, 1, 16'h0001, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h01, 16'h0001, 1));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h01, 16'h0001, 1));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd3, 0, 16'h0000, 8'h01, 16'h0001, 1));
      // edge source 2: latch, W1C, set-wins
      tbl.push_back(mk(3'd2, 1, 16'h0004, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd1, 1, 16'h0004, 8'h00, 16'h0001, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h04, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0004, 1));
      tbl.push_back(mk(3'd0, 1, 16'h0004, 8'h00, 16'h0004, 1));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 1, 16'h0004, 8'h04, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0004, 1));
      tbl.push_back(mk(3'd0, 1, 16'h0004, 8'h00, 16'h0004, 1));
      // priority ID on level sources 5 and 7
      tbl.push_back(mk(3'd1, 1, 16'h00A0, 8'hA0, 16'h0004, 0));
      tbl.push_back(mk(3'd4, 0, 16'h0000, 8'hA0, 16'h8005, 1));
      tbl.push_back(mk(3'd4, 0, 16'h0000, 8'h80, 16'h8007, 1));
      tbl.push_back(mk(3'd4, 0, 16'h0000, 8'h00, 16'h0000, 0));
      // SW_SET only latches edge sources; masked pending gives no irq
      tbl.push_back(mk(3'd2, 1, 16'h0001, 8'h00, 16'h0004, 0));
      tbl.push_back(mk(3'd1, 1, 16'h0000, 8'h00, 16'h00A0, 0));
      tbl.push_back(mk(3'd5, 1, 16'h0003, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0001, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0001, 0));
      // unmapped address and unimplemented bits
      tbl.push_back(mk(3'd6, 1, 16'hFFFF, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd1, 1, 16'hFFFF, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd1, 0, 16'h0000, 8'h00, 16'h00FF, 1));
      tbl.push_back(mk(3'd4, 0, 16'h0000, 8'h00, 16'h8000, 1));
      // edge -> level discards the latched bit
      tbl.push_back(mk(3'd2, 1, 16'h0000, 8'h00, 16'h0001, 1));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd2, 1, 16'h0001, 8'h00, 16'h0000, 0));
      tbl.push_back(mk(3'd0, 0, 16'h0000, 8'h00, 16'h0000, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset rd0", rd0, 16'h0000);
      chk("reset irq0", 16'(irq0), 16'h0000);
      chk("reset rd2", rd2, 16'h0000);
      chk("reset irq2", 16'(irq2), 16'h0000);
      reset_n = 1;

      for (int i = 0; i < tbl.size(); i++) begin
         addr0 = tbl[i].addr; cs0 = 1; wn0 = !tbl[i].wr; wd0 = tbl[i].wd; irqin0 = tbl[i].irqin;
         sb.push_back('{tbl[i].rd, tbl[i].irq});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("vec%0d rd", i), rd0, e.rd);
         chk($sformatf("vec%0d irq", i), 16'(irq0), 16'(e.irq));
      end
      wn0 = 1; addr0 = 3'd1; irqin0 = 8'hFE;

      // SYNC_STAGES=2 latency: line asserted before edge k
      cs2 = 1; wn2 = 0; addr2 = 3'd1; wd2 = 16'h0001;
      @(posedge clk); #1;
      wn2 = 1; addr2 = 3'd3; irqin2 = 8'h01;
      @(posedge clk); #1;
      chk("s2 k irq", 16'(irq2), 16'h0000);
      chk("s2 k rd", rd2, 16'h0000);
      @(posedge clk); #1;
      chk("s2 k+1 irq", 16'(irq2), 16'h0000);
      chk("s2 k+1 rd", rd2, 16'h0000);
      @(posedge clk); #1;
      chk("s2 k+2 irq", 16'(irq2), 16'h0001);
      @(posedge clk); #1;
      chk("s2 k+3 rd", rd2, 16'h0001);
      chk("s2 k+3 irq", 16'(irq2), 16'h0001);
      chk("u0 pre-reset rd", rd0, 16'h00FF);
      chk("u0 pre-reset irq", 16'(irq0), 16'h0001);

      // asynchronous reset mid-pulse
      #2 reset_n = 0;
      #1;
      chk("async rst irq2", 16'(irq2), 16'h0000);
      chk("async rst rd2", rd2, 16'h0000);
      chk("async rst irq0", 16'(irq0), 16'h0000);
      chk("async rst rd0", rd0, 16'h0000);
      @(negedge clk);
      reset_n = 1;
      @(posedge clk); #1;
      chk("post rst mask2", rd2, 16'h0000);
      chk("post rst mask0", rd0, 16'h0000);
      chk("post rst irq2", 16'(irq2), 16'h0000);
      chk("post rst irq0", 16'(irq0), 16'h0000);
      addr0 = 3'd2;
      @(posedge clk); #1;
      chk("post rst edge_sel0", rd0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
